// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared segment bus, per-slot blanking gap,
// and a valid/ready load path whose values only take effect at frame boundaries.
module seg_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  lz_en,
  input  logic                  load_valid,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic                  load_ready,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIG_W-1:0]     digit_q, digit_d;
  logic [4*DIGITS-1:0]  disp_q, disp_d;
  logic [4*DIGITS-1:0]  pend_q, pend_d;
  logic                 pending_q, pending_d;
  logic [6:0]           seg_q, seg_d;
  logic [DIGITS-1:0]    an_q, an_d;
  logic                 tick_q, tick_d;
  logic                 boundary;
  logic [3:0]           nib;
  logic                 lz_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    case (h)
      4'h0: seg_decode = 7'h01;
      4'h1: seg_decode = 7'h4F;
      4'h2: seg_decode = 7'h12;
      4'h3: seg_decode = 7'h06;
      4'h4: seg_decode = 7'h4C;
      4'h5: seg_decode = 7'h24;
      4'h6: seg_decode = 7'h20;
      4'h7: seg_decode = 7'h0F;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h04;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h60;
      4'hC: seg_decode = 7'h31;
      4'hD: seg_decode = 7'h42;
      4'hE: seg_decode = 7'h30;
      default: seg_decode = 7'h38;
    endcase
  endfunction

  // cnt runs across the whole slot: BLANK phase for 0..BLANK-1, DRIVE for the rest
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    digit_d   = digit_q;
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    boundary  = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      digit_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          cnt_d   = '0;
          digit_d = '0;
        end
        S_BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) state_d = S_DRIVE;
        end
        S_DRIVE: begin
          if (cnt_q == SLOT_LAST) begin
            cnt_d   = '0;
            state_d = S_BLANK;
            if (digit_q == DIG_LAST) begin
              digit_d  = '0;
              boundary = 1'b1;
            end else begin
              digit_d = digit_q + DIG_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // ready is low whenever a value is pending, so commit and accept never coincide
    tick_d = boundary;
    if (boundary && pending_q) begin
      disp_d    = pend_q;
      pending_d = 1'b0;
    end else if (load_valid && !pending_q) begin
      pend_d    = load_value;
      pending_d = 1'b1;
    end

    nib      = 4'h0;
    lz_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_d == DIG_W'(i)) nib = disp_d[4*i +: 4];
    end
    for (int i = 1; i < DIGITS; i++) begin
      if (lz_en && digit_d == DIG_W'(i) && (disp_d >> (4*i)) == '0) lz_blank = 1'b1;
    end

    seg_d = 7'h7F;
    an_d  = '1;
    if (state_d == S_DRIVE && !lz_blank) begin
      seg_d = seg_decode(nib);
      for (int i = 0; i < DIGITS; i++) begin
        if (digit_d == DIG_W'(i)) an_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      digit_q   <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      seg_q     <= 7'h7F;
      an_q      <= '1;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      tick_q    <= tick_d;
    end
  end

  // Holding register is only meaningful while pending_q is set
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  assign load_ready = ~pending_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (DIGITS=4, PRESCALE=8, BLANK=2): table vectors, hand sequences, random vs model.
module tb_seg_scan_ctrl;
  localparam int DIGITS = 4, PRESCALE = 8, BLANK = 2, FRAME = DIGITS * PRESCALE;

  logic        clk = 1'b0;
  logic        reset, enable, lz_en, load_valid;
  logic [15:0] load_value;
  logic        load_ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int n_vec = 0;
  int n_bad = 0;

  seg_scan_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .enable(enable), .lz_en(lz_en),
    .load_valid(load_valid), .load_value(load_value), .load_ready(load_ready),
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  logic [6:0] SEGTAB [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  typedef struct {
    logic [15:0]     val;
    logic            lz;
    logic [3:0]      lit;
    logic [3:0][6:0] segs;
  } vec_t;

  vec_t vt [7];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_disp(input string name, input logic [6:0] es, input logic [3:0] ea);
    n_vec++;
    if (seg !== es) begin
      n_bad++;
      $display("FAIL %s.seg: got %h, expected %h (t=%0t)", name, seg, es, $time);
    end
    n_vec++;
    if (an !== ea) begin
      n_bad++;
      $display("FAIL %s.an: got %b, expected %b (t=%0t)", name, an, ea, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a value, holding valid until accepted; returns one cycle after the transfer
  task automatic offer(input logic [15:0] v);
    int k;
    k = 0;
    while (!load_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk_bit("offer.ready", load_ready, 1'b1);
    load_valid = 1'b1;
    load_value = v;
    @(negedge clk);
    load_valid = 1'b0;
    chk_bit("offer.taken", load_ready, 1'b0);
  endtask

  // Returns at the first cycle of the frame in which the pending value became visible
  task automatic wait_ready(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!load_ready && k < 100);
    chk_bit({name, ".ready"}, load_ready, 1'b1);
    chk_bit({name, ".tick"}, frame_tick, 1'b1);
  endtask

  // Starts at frame position 0, ends at position FRAME-1
  task automatic observe_frame(input string name, input logic [3:0][6:0] segs, input logic [3:0] lit);
    logic [6:0] es;
    logic [3:0] ea;
    int slot;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      slot = k / PRESCALE;
      es = 7'h7F;
      ea = 4'hF;
      if ((k % PRESCALE) >= BLANK && lit[slot]) begin
        ea = ~(4'b0001 << slot);
        es = segs[slot];
      end
      chk_disp(name, es, ea);
    end
  endtask

  // Random-phase reference model state: pos is the cycle index within the frame, -1 when dark
  int          pos;
  int          slot;
  logic [15:0] m_disp, m_pend;
  logic        m_pending, m_tick, bnd;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic [15:0] masks [5] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF, 16'h0000};

  initial begin
    vt[0] = '{val: 16'h1234, lz: 1'b0, lit: 4'b1111, segs: {7'h4F, 7'h12, 7'h06, 7'h4C}};
    vt[1] = '{val: 16'h0007, lz: 1'b1, lit: 4'b0001, segs: {7'h7F, 7'h7F, 7'h7F, 7'h0F}};
    vt[2] = '{val: 16'h0000, lz: 1'b1, lit: 4'b0001, segs: {7'h7F, 7'h7F, 7'h7F, 7'h01}};
    vt[3] = '{val: 16'h0000, lz: 1'b0, lit: 4'b1111, segs: {7'h01, 7'h01, 7'h01, 7'h01}};
    vt[4] = '{val: 16'h00A5, lz: 1'b1, lit: 4'b0011, segs: {7'h7F, 7'h7F, 7'h08, 7'h24}};
    vt[5] = '{val: 16'h0F0E, lz: 1'b1, lit: 4'b0111, segs: {7'h7F, 7'h38, 7'h01, 7'h30}};
    vt[6] = '{val: 16'hBCDE, lz: 1'b0, lit: 4'b1111, segs: {7'h60, 7'h31, 7'h42, 7'h30}};

    reset = 1'b1; enable = 1'b1; lz_en = 1'b0; load_valid = 1'b0; load_value = 16'h0;

    // Reset held three cycles, then scanning starts
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_disp("reset", 7'h7F, 4'hF);
    chk_bit("reset.ready", load_ready, 1'b1);
    chk_bit("reset.tick", frame_tick, 1'b0);
    reset = 1'b0;
    step(1);
    chk_disp("first_blank", 7'h7F, 4'hF);
    step(2);
    chk_disp("first_drive", 7'h01, 4'b1110);

    // Load 1234: current frame keeps showing zeros
    offer(16'h1234);
    step(23);
    chk_disp("old_frame_d3", 7'h01, 4'b0111);
    wait_ready("load1234");
    observe_frame("v1234", vt[0].segs, vt[0].lit);

    for (int i = 1; i < 7; i++) begin
      lz_en = vt[i].lz;
      offer(vt[i].val);
      wait_ready("table");
      observe_frame($sformatf("vec%0d", i), vt[i].segs, vt[i].lit);
    end

    // Back-to-back offers; first transfer lands in the boundary cycle itself
    lz_en = 1'b0;
    load_valid = 1'b1;
    load_value = 16'h00A5;
    @(negedge clk);
    load_value = 16'h1111;
    chk_bit("b2b.ready", load_ready, 1'b0);
    chk_bit("b2b.tick", frame_tick, 1'b1);
    wait_ready("b2b");
    load_valid = 1'b0;
    observe_frame("b2b_disp", {7'h01, 7'h01, 7'h08, 7'h24}, 4'b1111);
    chk_bit("b2b.ready_after", load_ready, 1'b1);

    // Enable drop during digit-2 DRIVE with a value pending
    offer(16'hBEEF);
    step(19);
    chk_disp("en_drop.before", 7'h01, 4'b1011);
    enable = 1'b0;
    step(1);
    chk_disp("en_drop.dark", 7'h7F, 4'hF);
    chk_bit("en_drop.pending", load_ready, 1'b0);
    step(5);
    chk_disp("en_drop.still_dark", 7'h7F, 4'hF);
    chk_bit("en_drop.tick", frame_tick, 1'b0);
    enable = 1'b1;
    step(1);
    chk_disp("reen.blank", 7'h7F, 4'hF);
    step(2);
    chk_disp("reen.d0", 7'h24, 4'b1110);
    wait_ready("reen");
    observe_frame("beef", {7'h60, 7'h30, 7'h30, 7'h38}, 4'b1111);

    // Reset mid-frame discards the pending value
    offer(16'h7777);
    step(12);
    reset = 1'b1;
    step(1);
    chk_disp("midreset", 7'h7F, 4'hF);
    chk_bit("midreset.ready", load_ready, 1'b1);
    chk_bit("midreset.tick", frame_tick, 1'b0);
    reset = 1'b0;
    step(3);
    chk_disp("midreset.d0", 7'h01, 4'b1110);
    step(24);
    chk_disp("midreset.d3", 7'h01, 4'b0111);
    step(6);
    chk_bit("midreset.tick2", frame_tick, 1'b1);
    chk_bit("midreset.ready2", load_ready, 1'b1);
    step(2);
    chk_disp("midreset.d0_next", 7'h01, 4'b1110);

    // Random traffic against the frame-position model
    pos = -1; m_disp = '0; m_pend = '0; m_pending = 1'b0; m_tick = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset = (c == 0) || ($urandom_range(0, 999) == 0);
      if (enable && $urandom_range(0, 99) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
      if (c % 256 == 0) lz_en = 1'($urandom_range(0, 1));
      load_valid = ($urandom_range(0, 3) == 0);
      load_value = 16'($urandom) & masks[$urandom_range(0, 4)];

      if (reset) begin
        pos = -1; m_disp = '0; m_pending = 1'b0; m_tick = 1'b0;
      end else begin
        bnd = enable && pos >= 0 && (pos % FRAME) == FRAME - 1;
        m_tick = bnd;
        if (bnd && m_pending) begin
          m_disp = m_pend;
          m_pending = 1'b0;
        end else if (load_valid && !m_pending) begin
          m_pend = load_value;
          m_pending = 1'b1;
        end
        pos = enable ? (pos + 1) % FRAME : -1;
      end
      e_seg = 7'h7F;
      e_an = 4'hF;
      if (pos >= 0 && (pos % PRESCALE) >= BLANK) begin
        slot = pos / PRESCALE;
        if (!(lz_en && slot > 0 && (m_disp >> (4 * slot)) == 16'h0)) begin
          e_an[slot] = 1'b0;
          e_seg = SEGTAB[m_disp[4*slot +: 4]];
        end
      end

      @(negedge clk);
      chk_disp("rand", e_seg, e_an);
      chk_bit("rand.ready", load_ready, !m_pending);
      chk_bit("rand.tick", frame_tick, m_tick);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
